alu_md: RTL and testbench
=========================

Name: alu_md

Overview:
- Parametrised successor to the single-cycle integer ALU in the execute stage.
- Keeps the combinational ALU path: result and equality flag valid in the same cycle.
- Adds a multi-cycle multiply/divide engine with architectural HI/LO registers and a start/busy handshake.
- The hazard unit stalls MFHI/MFLO and any new multiply/divide while busy is high.

Parameters:
- WIDTH, 32, operand, result and HI/LO width (8..64).
- MUL_CYCLES, 5, cycles busy is high for MULT/MULTU (>=1).
- DIV_CYCLES, 10, cycles busy is high for DIV/DIVU (>=1).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising edge of clk.
- alu_input1  input  WIDTH  operand A (rs).
- alu_input2  input  WIDTH  operand B (rt or extended immediate).
- aluop  input  4  combinational op select.
- md_op  input  3  multiply/divide op select; sampled only when start=1.
- start  input  1  one-cycle request to execute md_op.
- alu_out  output  WIDTH  combinational result.
- alu_zero  output  1  1 when alu_input1==alu_input2 (branch compare), independent of aluop.
- busy  output  1  multiply/divide in progress.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- aluop encodings:
  - 0 AND, 1 OR, 2 ADD, 3 SUB (wrap-around, no overflow flag).
  - 4 XOR, 5 NOR.
  - 6 SLT (signed, result 0/1 zero-extended), 7 SLTU.
  - 8 SLL, 9 SRL, 10 SRA: shift alu_input2 by alu_input1[$clog2(WIDTH)-1:0].
  - 11 LUI: alu_input2 << WIDTH/2.
  - 12-15: alu_out=0.
- alu_out and alu_zero are purely combinational; unaffected by busy or reset.
- md_op encodings: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op.
- Reset: busy=0, hi=0, lo=0, internal counter=0. Reset mid-operation aborts the operation; no HI/LO write follows.
- Start accepted on an edge where start=1, busy=0 and reset=0:
  - MULT/MULTU/DIV/DIVU: operands and md_op are latched; counter loads N (MUL_CYCLES or DIV_CYCLES); busy=1 from the next cycle.
  - MTHI: hi<=alu_input1 on the same edge; busy stays 0.
  - MTLO: lo<=alu_input1 on the same edge; busy stays 0.
  - md_op 6-7: no effect.
- Start while busy=1: ignored entirely, including MTHI/MTLO; no queuing.
- While busy, counter decrements each edge. On the edge where counter==1: hi/lo are written and busy<=0 on that same edge. busy is therefore high for exactly N cycles.
- Operand changes after the accept edge have no effect on the result.
- Back-to-back: start may be accepted in the first cycle busy=0 after completion.
- MULT: {hi,lo} = signed A*B, full 2*WIDTH product.
- MULTU: {hi,lo} = unsigned A*B, full 2*WIDTH product.
- DIV: lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
- DIVU: unsigned quotient and remainder.
- Divide by zero (DIV and DIVU): lo=all ones, hi=dividend.
- Signed overflow (DIV, A=-2^(WIDTH-1), B=-1): lo=A, hi=0.
- hi/lo hold their values at all other times. They are readable during busy, showing the previous values.

Test Plan:
- Reset then ALU sweep, WIDTH=32: A=0xFFFF0000, B=0x0000FFFF.
  - AND->0, OR->0xFFFFFFFF, XOR->0xFFFFFFFF, NOR->0.
  - SLT(A=0xFFFFFFFF,B=1)->1; SLTU->0.
  - SRA(A=4,B=0x80000000)->0xF8000000.
  - LUI(B=0x1234)->0x12340000.
  - alu_zero=0 for these operands; A=B=7 -> alu_zero=1.
- MULT A=0xFFFFFFFE(-2), B=3, start 1 cycle:
  - busy high exactly 5 cycles.
  - hi=0xFFFFFFFF, lo=0xFFFFFFFA on the busy-falling edge.
  - MULTU on the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV A=-7, B=2 -> lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1), busy 10 cycles.
  - DIVU 7/0 -> lo=0xFFFFFFFF, hi=7.
  - DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- MTHI 0xAAAA5555 while busy=1 -> ignored, hi becomes the multiply result.
  - MTLO 0x1234 while idle -> lo=0x1234 on the next edge, busy stays 0.
- Assert reset in cycle 3 of a DIV:
  - next edge: busy=0, hi=lo=0.
  - no later HI/LO write.
  - new MULT accepted immediately after reset deasserts.
- Operand change during busy, plus a back-to-back start in the first idle cycle:
  - change operands during busy -> result still reflects the latched operands.
  - start in the first busy=0 cycle is accepted, with correct second result.
  - repeat with WIDTH=16, MUL_CYCLES=1: busy high exactly 1 cycle.

Source files
------------

// File: rtl/alu_md.sv
// alu_md: execute-stage integer ALU with an attached multi-cycle multiply/divide
// unit that owns the architectural HI/LO registers.
// Ports:
//   clk, reset            - single clock; synchronous active-high reset
//   alu_input1/alu_input2 - operands A (rs) and B (rt / extended immediate)
//   aluop                 - selects the combinational result on alu_out
//   alu_out, alu_zero     - combinational result and A==B flag
//   md_op, start          - multiply/divide/MTHI/MTLO request, sampled when start=1
//   busy                  - high while a multiply/divide is in flight
//   hi, lo                - architectural HI/LO registers
module alu_md #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] alu_input1,
  input  logic [WIDTH-1:0] alu_input2,
  input  logic [3:0]       aluop,
  input  logic [2:0]       md_op,
  input  logic             start,
  output logic [WIDTH-1:0] alu_out,
  output logic             alu_zero,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int SHW   = $clog2(WIDTH);
  localparam int MAXC  = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_MUL = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_DIV = CNT_W'(DIV_CYCLES);

  logic [SHW-1:0]   shamt_s;
  logic             busy_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] a_r, b_r, hi_r, lo_r;
  logic [WIDTH-1:0] res_hi_s, res_lo_s;

  logic signed [2*WIDTH-1:0] sa_x_s, sb_x_s, prod_s_s;
  logic [2*WIDTH-1:0]        prod_u_s;
  logic                      signed_div_s, a_neg_s, b_neg_s;
  logic [WIDTH-1:0]          a_mag_s, b_mag_s, uq_s, ur_s, q_s, r_s;

  assign shamt_s = alu_input1[SHW-1:0];

  // Combinational ALU result selected by aluop.
  always_comb begin
    alu_out = {WIDTH{1'b0}};
    case (aluop)
      4'd0:    alu_out = alu_input1 & alu_input2;
      4'd1:    alu_out = alu_input1 | alu_input2;
      4'd2:    alu_out = alu_input1 + alu_input2;
      4'd3:    alu_out = alu_input1 - alu_input2;
      4'd4:    alu_out = alu_input1 ^ alu_input2;
      4'd5:    alu_out = ~(alu_input1 | alu_input2);
      4'd6:    alu_out = {{(WIDTH-1){1'b0}}, ($signed(alu_input1) < $signed(alu_input2))};
      4'd7:    alu_out = {{(WIDTH-1){1'b0}}, (alu_input1 < alu_input2)};
      4'd8:    alu_out = alu_input2 << shamt_s;
      4'd9:    alu_out = alu_input2 >> shamt_s;
      4'd10:   alu_out = $signed(alu_input2) >>> shamt_s;
      4'd11:   alu_out = alu_input2 << (WIDTH / 2);
      default: alu_out = {WIDTH{1'b0}};
    endcase
  end

  assign alu_zero = (alu_input1 == alu_input2);

  // Full-width products of the latched operands.
  assign sa_x_s   = {{WIDTH{a_r[WIDTH-1]}}, a_r};
  assign sb_x_s   = {{WIDTH{b_r[WIDTH-1]}}, b_r};
  assign prod_s_s = sa_x_s * sb_x_s;
  assign prod_u_s = {{WIDTH{1'b0}}, a_r} * {{WIDTH{1'b0}}, b_r};

  // Signed divide runs on magnitudes through one unsigned divider, then the
  // signs are restored. -2^(W-1)/-1 falls out naturally: its magnitude fits in
  // W unsigned bits and the re-signed quotient wraps back to -2^(W-1).
  assign signed_div_s = (op_r == MD_DIV);
  assign a_neg_s      = signed_div_s & a_r[WIDTH-1];
  assign b_neg_s      = signed_div_s & b_r[WIDTH-1];
  assign a_mag_s      = a_neg_s ? -a_r : a_r;
  assign b_mag_s      = b_neg_s ? -b_r : b_r;
  assign uq_s         = a_mag_s / b_mag_s;
  assign ur_s         = a_mag_s % b_mag_s;
  assign q_s          = (a_neg_s ^ b_neg_s) ? -uq_s : uq_s;
  assign r_s          = a_neg_s ? -ur_s : ur_s;

  // HI/LO values written when the running operation completes.
  always_comb begin
    res_hi_s = {WIDTH{1'b0}};
    res_lo_s = {WIDTH{1'b0}};
    case (op_r)
      MD_MULT:  {res_hi_s, res_lo_s} = prod_s_s;
      MD_MULTU: {res_hi_s, res_lo_s} = prod_u_s;
      MD_DIV, MD_DIVU: begin
        if (b_r == {WIDTH{1'b0}}) begin
          res_lo_s = {WIDTH{1'b1}};
          res_hi_s = a_r;
        end else begin
          res_lo_s = q_s;
          res_hi_s = r_s;
        end
      end
      default: begin
        res_hi_s = {WIDTH{1'b0}};
        res_lo_s = {WIDTH{1'b0}};
      end
    endcase
  end

  // Start handshake, cycle counter and HI/LO updates; busy starts are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= 1'b0;
      cnt_r  <= {CNT_W{1'b0}};
      op_r   <= 3'd0;
      a_r    <= {WIDTH{1'b0}};
      b_r    <= {WIDTH{1'b0}};
      hi_r   <= {WIDTH{1'b0}};
      lo_r   <= {WIDTH{1'b0}};
    end else if (busy_r) begin
      if (cnt_r == CNT_ONE) begin
        hi_r   <= res_hi_s;
        lo_r   <= res_lo_s;
        busy_r <= 1'b0;
        cnt_r  <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r - CNT_ONE;
      end
    end else if (start) begin
      case (md_op)
        MD_MULT, MD_MULTU: begin
          op_r   <= md_op;
          a_r    <= alu_input1;
          b_r    <= alu_input2;
          cnt_r  <= CNT_MUL;
          busy_r <= 1'b1;
        end
        MD_DIV, MD_DIVU: begin
          op_r   <= md_op;
          a_r    <= alu_input1;
          b_r    <= alu_input2;
          cnt_r  <= CNT_DIV;
          busy_r <= 1'b1;
        end
        MD_MTHI: hi_r <= alu_input1;
        MD_MTLO: lo_r <= alu_input1;
        default: begin
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign hi   = hi_r;
  assign lo   = lo_r;
endmodule

// File: tb/tb_alu_md.sv
// tb_alu_md: drives a WIDTH=32 instance (5/10 cycles) and a WIDTH=16 instance
// (1/3 cycles) with directed vectors. A cycle-level reference model built
// from plain arithmetic is compared against every output on every falling
// edge, and hand-computed literals pin the model on key cases.
module tb_alu_md;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  logic [31:0] a_s[2], b_s[2];
  logic [3:0]  aluop_s[2];
  logic [2:0]  mdop_s[2];
  logic        start_s[2], reset_s[2];

  logic [31:0] out32, hi32, lo32;
  logic        zero32, busy32;
  logic [15:0] out16, hi16, lo16;
  logic        zero16, busy16;

  alu_md #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut32 (
    .clk(clk), .reset(reset_s[0]), .alu_input1(a_s[0]), .alu_input2(b_s[0]),
    .aluop(aluop_s[0]), .md_op(mdop_s[0]), .start(start_s[0]),
    .alu_out(out32), .alu_zero(zero32), .busy(busy32), .hi(hi32), .lo(lo32));

  alu_md #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(3)) dut16 (
    .clk(clk), .reset(reset_s[1]), .alu_input1(a_s[1][15:0]), .alu_input2(b_s[1][15:0]),
    .aluop(aluop_s[1]), .md_op(mdop_s[1]), .start(start_s[1]),
    .alu_out(out16), .alu_zero(zero16), .busy(busy16), .hi(hi16), .lo(lo16));

  function automatic int wof(int j);  return (j == 0) ? 32 : 16; endfunction
  function automatic int nmul(int j); return (j == 0) ? 5 : 1;   endfunction
  function automatic int ndiv(int j); return (j == 0) ? 10 : 3;  endfunction

  function automatic logic [63:0] g_out(int j);  return (j == 0) ? {32'h0, out32} : {48'h0, out16}; endfunction
  function automatic logic [63:0] g_hi(int j);   return (j == 0) ? {32'h0, hi32}  : {48'h0, hi16};  endfunction
  function automatic logic [63:0] g_lo(int j);   return (j == 0) ? {32'h0, lo32}  : {48'h0, lo16};  endfunction
  function automatic logic        g_busy(int j); return (j == 0) ? busy32 : busy16; endfunction
  function automatic logic        g_zero(int j); return (j == 0) ? zero32 : zero16; endfunction

  function automatic logic [63:0] msk(int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic longint sx(logic [63:0] v, int w);
    logic [63:0] m;
    m = msk(w);
    if (v[w-1]) return longint'(v | ~m);
    else        return longint'(v & m);
  endfunction

  // Reference ALU: plain arithmetic on w-bit values.
  function automatic logic [63:0] alu_ref(int w, logic [3:0] op, logic [63:0] a, logic [63:0] b);
    logic [63:0] m, ua, ub, r;
    int sh;
    m = msk(w); ua = a & m; ub = b & m;
    sh = int'(ua & 64'(w - 1));
    case (op)
      4'd0:    r = ua & ub;
      4'd1:    r = ua | ub;
      4'd2:    r = ua + ub;
      4'd3:    r = ua - ub;
      4'd4:    r = ua ^ ub;
      4'd5:    r = ~(ua | ub);
      4'd6:    r = (sx(a, w) < sx(b, w)) ? 64'd1 : 64'd0;
      4'd7:    r = (ua < ub) ? 64'd1 : 64'd0;
      4'd8:    r = ub << sh;
      4'd9:    r = ub >> sh;
      4'd10:   r = 64'(sx(b, w) >>> sh);
      4'd11:   r = ub << (w / 2);
      default: r = 64'd0;
    endcase
    return r & m;
  endfunction

  // Reference multiply/divide: {hi,lo} packed as hi<<w | lo.
  function automatic logic [63:0] md_res(int w, logic [2:0] op, logic [63:0] a, logic [63:0] b);
    logic [63:0] m, ua, ub, p, lo_v, hi_v;
    longint sa, sb, ma, mb, sq, sr;
    m = msk(w); ua = a & m; ub = b & m;
    sa = sx(a, w); sb = sx(b, w);
    lo_v = 64'd0; hi_v = 64'd0;
    case (op)
      3'd0: begin p = 64'(sa * sb); lo_v = p & m; hi_v = (p >> w) & m; end
      3'd1: begin p = ua * ub;      lo_v = p & m; hi_v = (p >> w) & m; end
      3'd2: begin
        if (sb == 0) begin lo_v = m; hi_v = ua; end
        else begin
          ma = (sa < 0) ? -sa : sa;
          mb = (sb < 0) ? -sb : sb;
          sq = ma / mb; sr = ma % mb;
          if ((sa < 0) != (sb < 0)) sq = -sq;
          if (sa < 0) sr = -sr;
          lo_v = 64'(sq) & m; hi_v = 64'(sr) & m;
        end
      end
      3'd3: begin
        if (ub == 64'd0) begin lo_v = m; hi_v = ua; end
        else begin lo_v = ua / ub; hi_v = ua % ub; end
      end
      default: begin lo_v = 64'd0; hi_v = 64'd0; end
    endcase
    return (hi_v << w) | lo_v;
  endfunction

  function automatic logic [63:0] md_hi(int w, logic [2:0] op, logic [63:0] a, logic [63:0] b);
    return (md_res(w, op, a, b) >> w) & msk(w);
  endfunction
  function automatic logic [63:0] md_lo(int w, logic [2:0] op, logic [63:0] a, logic [63:0] b);
    return md_res(w, op, a, b) & msk(w);
  endfunction

  // Model state: pending result plus the absolute cycle it lands on.
  logic        m_pend[2];
  int          m_fin[2];
  logic [63:0] m_hi[2], m_lo[2], p_hi[2], p_lo[2];

  always @(posedge clk) begin
    for (int j = 0; j < 2; j++) begin
      if (reset_s[j]) begin
        m_pend[j] <= 1'b0; m_hi[j] <= 64'd0; m_lo[j] <= 64'd0;
      end else if (m_pend[j]) begin
        if (cyc == m_fin[j]) begin
          m_hi[j] <= p_hi[j]; m_lo[j] <= p_lo[j]; m_pend[j] <= 1'b0;
        end
      end else if (start_s[j]) begin
        if (mdop_s[j] <= 3'd3) begin
          p_hi[j]   <= md_hi(wof(j), mdop_s[j], {32'h0, a_s[j]}, {32'h0, b_s[j]});
          p_lo[j]   <= md_lo(wof(j), mdop_s[j], {32'h0, a_s[j]}, {32'h0, b_s[j]});
          m_fin[j]  <= cyc + ((mdop_s[j] < 3'd2) ? nmul(j) : ndiv(j));
          m_pend[j] <= 1'b1;
        end else if (mdop_s[j] == 3'd4) begin
          m_hi[j] <= {32'h0, a_s[j]} & msk(wof(j));
        end else if (mdop_s[j] == 3'd5) begin
          m_lo[j] <= {32'h0, a_s[j]} & msk(wof(j));
        end
      end
    end
    cyc <= cyc + 1;
  end

  task automatic check(string nm, int j, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[w%0d] t=%0t got=%h want=%h", nm, wof(j), $time, act, exp);
    end
  endtask

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int j = 0; j < 2; j++) begin
        check("alu_out", j, g_out(j), alu_ref(wof(j), aluop_s[j], {32'h0, a_s[j]}, {32'h0, b_s[j]}));
        check("alu_zero", j, {63'h0, g_zero(j)},
              {63'h0, ((({32'h0, a_s[j]} ^ {32'h0, b_s[j]}) & msk(wof(j))) == 64'd0)});
        check("busy", j, {63'h0, g_busy(j)}, {63'h0, m_pend[j]});
        check("hi", j, g_hi(j), m_hi[j]);
        check("lo", j, g_lo(j), m_lo[j]);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_alu(int j, string nm, logic [3:0] op, logic [31:0] a, logic [31:0] b,
                         logic [31:0] exp_out, logic exp_z);
    tick();
    a_s[j] = a; b_s[j] = b; aluop_s[j] = op;
    @(negedge clk);
    check(nm, j, g_out(j), {32'h0, exp_out});
    check({nm, "_zero"}, j, {63'h0, g_zero(j)}, {63'h0, exp_z});
  endtask

  task automatic start_md(int j, logic [2:0] op, logic [31:0] a, logic [31:0] b);
    a_s[j] = a; b_s[j] = b; mdop_s[j] = op; start_s[j] = 1'b1;
    tick();
    start_s[j] = 1'b0;
  endtask

  task automatic wait_idle(int j, output int n);
    bit done;
    n = 0; done = 1'b0;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      if (g_busy(j)) n++;
      else done = 1'b1;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL timeout[w%0d] busy still high after 64 cycles", wof(j));
    end
  endtask

  task automatic chk_hilo(int j, string nm, logic [31:0] eh, logic [31:0] el);
    check({nm, "_hi"}, j, g_hi(j), {32'h0, eh});
    check({nm, "_lo"}, j, g_lo(j), {32'h0, el});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int j = 0; j < 2; j++) begin
      a_s[j] = 32'h0; b_s[j] = 32'h0; aluop_s[j] = 4'd0; mdop_s[j] = 3'd0;
      start_s[j] = 1'b0; reset_s[j] = 1'b1;
    end
    tick(); tick();
    @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      check("rst_busy", j, {63'h0, g_busy(j)}, 64'd0);
      chk_hilo(j, "rst", 32'h0, 32'h0);
    end
    chk_en = 1'b1;
    #1;
    reset_s[0] = 1'b0; reset_s[1] = 1'b0;

    // ALU sweep
    chk_alu(0, "and",  4'd0,  32'hFFFF0000, 32'h0000FFFF, 32'h00000000, 1'b0);
    chk_alu(0, "or",   4'd1,  32'hFFFF0000, 32'h0000FFFF, 32'hFFFFFFFF, 1'b0);
    chk_alu(0, "xor",  4'd4,  32'hFFFF0000, 32'h0000FFFF, 32'hFFFFFFFF, 1'b0);
    chk_alu(0, "nor",  4'd5,  32'hFFFF0000, 32'h0000FFFF, 32'h00000000, 1'b0);
    chk_alu(0, "add",  4'd2,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0);
    chk_alu(0, "sub",  4'd3,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0);
    chk_alu(0, "slt",  4'd6,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0);
    chk_alu(0, "sltu", 4'd7,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0);
    chk_alu(0, "sll",  4'd8,  32'h00000004, 32'h00000001, 32'h00000010, 1'b0);
    chk_alu(0, "srl",  4'd9,  32'h0000001F, 32'h80000000, 32'h00000001, 1'b0);
    chk_alu(0, "sra",  4'd10, 32'h00000004, 32'h80000000, 32'hF8000000, 1'b0);
    chk_alu(0, "lui",  4'd11, 32'h00000000, 32'h00001234, 32'h12340000, 1'b0);
    chk_alu(0, "op12", 4'd12, 32'h00000007, 32'h00000007, 32'h00000000, 1'b1);
    chk_alu(0, "eq",   4'd2,  32'h00000007, 32'h00000007, 32'h0000000E, 1'b1);

    // MULT -2*3
    tick();
    start_md(0, 3'd0, 32'hFFFFFFFE, 32'd3);
    wait_idle(0, n);
    check("mult_len", 0, 64'(n), 64'd5);
    chk_hilo(0, "mult", 32'hFFFFFFFF, 32'hFFFFFFFA);

    // MULTU on the same operands, with an MTHI issued while busy
    tick();
    start_md(0, 3'd1, 32'hFFFFFFFE, 32'd3);
    tick();
    start_md(0, 3'd4, 32'hAAAA5555, 32'd0);
    wait_idle(0, n);
    chk_hilo(0, "multu", 32'h00000002, 32'hFFFFFFFA);

    // MTLO while idle
    tick();
    start_md(0, 3'd5, 32'h00001234, 32'd0);
    @(negedge clk);
    check("mtlo_busy", 0, {63'h0, g_busy(0)}, 64'd0);
    chk_hilo(0, "mtlo", 32'h00000002, 32'h00001234);

    // DIV -7/2, then DIVU 7/0 and DIV overflow back-to-back
    tick();
    start_md(0, 3'd2, 32'hFFFFFFF9, 32'd2);
    wait_idle(0, n);
    check("div_len", 0, 64'(n), 64'd10);
    chk_hilo(0, "div", 32'hFFFFFFFF, 32'hFFFFFFFD);
    #1;
    start_md(0, 3'd3, 32'd7, 32'd0);
    wait_idle(0, n);
    check("divu0_len", 0, 64'(n), 64'd10);
    chk_hilo(0, "divu0", 32'h00000007, 32'hFFFFFFFF);
    #1;
    start_md(0, 3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(0, n);
    chk_hilo(0, "divovf", 32'h00000000, 32'h80000000);

    // Reset in the third busy cycle of a DIV, then an immediate MULT
    tick();
    start_md(0, 3'd2, 32'd100, 32'd7);
    tick(); tick();
    reset_s[0] = 1'b1;
    tick();
    @(negedge clk);
    check("rstmid_busy", 0, {63'h0, g_busy(0)}, 64'd0);
    chk_hilo(0, "rstmid", 32'h0, 32'h0);
    #1;
    reset_s[0] = 1'b0;
    start_md(0, 3'd0, 32'd6, 32'd7);
    wait_idle(0, n);
    check("postrst_len", 0, 64'(n), 64'd5);
    chk_hilo(0, "postrst", 32'h0, 32'h0000002A);
    repeat (8) tick();
    @(negedge clk);
    chk_hilo(0, "nolate", 32'h0, 32'h0000002A);

    // Operand changes during busy, and back-to-back start
    tick();
    start_md(0, 3'd1, 32'd10, 32'd20);
    a_s[0] = 32'hFFFFFFFF; b_s[0] = 32'hFFFFFFFF;
    wait_idle(0, n);
    chk_hilo(0, "opchg", 32'h0, 32'h000000C8);
    #1;
    start_md(0, 3'd3, 32'd100, 32'd7);
    a_s[0] = 32'h0; b_s[0] = 32'h0;
    wait_idle(0, n);
    check("b2b_len", 0, 64'(n), 64'd10);
    chk_hilo(0, "b2b", 32'h00000002, 32'h0000000E);

    // WIDTH=16, MUL_CYCLES=1
    chk_alu(1, "sra16", 4'd10, 32'h00000004, 32'h00008000, 32'h0000F800, 1'b0);
    tick();
    start_md(1, 3'd0, 32'h0000FFFE, 32'd3);
    wait_idle(1, n);
    check("mult16_len", 1, 64'(n), 64'd1);
    chk_hilo(1, "mult16", 32'h0000FFFF, 32'h0000FFFA);
    #1;
    start_md(1, 3'd2, 32'h0000FFF9, 32'd2);
    a_s[1] = 32'h0; b_s[1] = 32'h0;
    wait_idle(1, n);
    check("div16_len", 1, 64'(n), 64'd3);
    chk_hilo(1, "div16", 32'h0000FFFF, 32'h0000FFFD);

    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
